uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, companion to the core's transmitter: same bit-rate, payload and framing
//  parameters. Synchronises the asynchronous rx pin, finds start bits, samples each bit at
//  mid-bit and delivers bytes LSB-first over a valid/ready handshake. Flags framing errors,
//  line breaks and overruns. Sits between the rx pad and the core's peripheral/IO logic.
// PARAMETERS
//  BIT_RATE      9600        line bit rate, bits/s
//  CLK_HZ        50_000_000  clk frequency, Hz
//  PAYLOAD_BITS  8           data bits per frame
//  (local) CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide); HALF_BIT = CYCLES_PER_BIT/2
//  (local) counter width = 1+$clog2(CYCLES_PER_BIT)
// PORTS
//  clk               in   1             system clock
//  reset             in   1             asynchronous, active-high reset
//  uart_rxd          in   1             rx pin, asynchronous, idle high
//  uart_rx_en        in   1             receiver enable
//  uart_rx_ready     in   1             consumer accepts uart_rx_data this cycle
//  uart_rx_valid     out  1             uart_rx_data holds an unconsumed byte
//  uart_rx_data      out  PAYLOAD_BITS  received byte
//  uart_rx_frame_err out  1             1-cycle pulse: stop bit sampled low
//  uart_rx_break     out  1             1-cycle pulse: frame error with all-zero data
//  uart_rx_overrun   out  1             sticky: good frame dropped because valid was held
// BEHAVIOUR
//  Reset: valid=0, data=0, frame_err=0, break=0, overrun=0; FSM=IDLE; counter=0;
//   both synchroniser flops=1. Reset mid-frame discards the frame; no output pulses.
//  rxd_s = uart_rxd through 2-flop synchroniser (2-cycle lag). Sampling uses rxd_s only.
//  FSM:
//   IDLE : rxd_s==0 && uart_rx_en -> START, counter=0.
//   START: at counter==HALF_BIT-1: rxd_s==0 -> DATA, counter=0; rxd_s==1 -> IDLE (glitch).
//   DATA : sample rxd_s at counter==CYCLES_PER_BIT-1, shift in at MSB (LSB arrives first),
//          counter=0; after PAYLOAD_BITS samples -> STOP.
//   STOP : sample at counter==CYCLES_PER_BIT-1. Sample 1: good frame, -> IDLE.
//          Sample 0: frame_err pulse (+break if shift reg all zero), -> WAIT_HI.
//   WAIT_HI: stay until rxd_s==1, then -> IDLE (break held low never re-triggers).
//  Timing: rxd_s falls at cycle t0 -> start sample t0+HALF_BIT-1; data bit k sampled
//   CYCLES_PER_BIT*(k+1) cycles later; stop sampled CYCLES_PER_BIT*(PAYLOAD_BITS+1) after
//   start sample. valid/pulses rise on the edge that takes the stop sample.
//  uart_rx_en=0 in any non-IDLE state: abort to IDLE next edge, frame discarded, no pulses.
//   Does not touch valid/data/overrun.
//  Handshake: byte consumed on an edge where valid && ready. valid stays 1 and data is
//   stable until consumed. ready with valid=0 has no effect.
//  Good frame completes:
//   valid==0, or valid && ready same cycle -> data=new byte, valid=1, overrun unchanged.
//   valid && !ready -> new byte dropped, data unchanged, overrun=1.
//  overrun clears on any consuming edge, unless a drop occurs that same edge (cannot, see
//   above). Frame-error frames never load data and never set overrun.
//  Frames may be back-to-back: IDLE re-arms at mid stop bit, so the next start edge is
//   caught with no lost cycles.
// TESTING (CLK_HZ=1_000_000, BIT_RATE=100_000 -> CYCLES_PER_BIT=10, HALF_BIT=5)
//  1 Drive 0xA5, 8N1, ready=0 -> valid=1, data=0xA5, held 50 cycles; ready=1 -> valid=0
//    next edge, overrun=0.
//  2 Drive 0x00 with stop bit low, line held low 200 cycles -> one frame_err and one break
//    pulse, valid stays 0, no further start detected until rxd returns high.
//  3 3-cycle low glitch on idle line -> FSM returns to IDLE, no valid, no frame_err.
//  4 Send 0x12 then 0x34, ready=0 -> data=0x12, overrun=1; ready 1 cycle -> valid=0,
//    overrun=0.
//  5 Send 0x55, 0x3C back-to-back (no idle gap); ready=1 only on 0x3C completion cycle
//    -> data=0x3C, valid=1, overrun=0.
//  6 Assert reset at data bit 4 of 0xFF, release, send 0x81 -> only 0x81 delivered, no
//    frame_err; uart_rx_en=0 mid-frame -> frame discarded.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: synchronises the rx pin, samples each bit at mid-bit and
// delivers LSB-first bytes over a valid/ready handshake, with frame-error,
// break and overrun reporting.
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic                    uart_rx_ready,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break,
    output logic                    uart_rx_overrun
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
    localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_rxd_meta;
    logic                    r_rxd_s;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [BIT_W-1:0]        w_bit_nxt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    w_shift_en;
    logic                    w_good;
    logic                    w_ferr;
    logic                    w_consume;

    logic                    r_valid;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_frame_err;
    logic                    r_break;
    logic                    r_overrun;

    assign w_consume = r_valid && uart_rx_ready;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // FSM state, bit-period counter and received-bit counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_nxt;
        end
    end

    // Next-state logic: start qualification at half a bit, then one sample per bit period.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit_cnt;
        w_shift_en  = 1'b0;
        w_good      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (!r_rxd_s && uart_rx_en) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF_END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt  = '0;
                    w_shift_en = 1'b1;
                    w_bit_nxt  = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt = '0;
                    if (r_rxd_s) begin
                        w_good      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                // A held-low line (break) must not look like a fresh start bit.
                w_cnt_nxt = '0;
                if (r_rxd_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
        // Disabling the receiver mid-frame silently discards the frame.
        if (r_state != S_IDLE && !uart_rx_en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_shift_en  = 1'b0;
            w_good      = 1'b0;
            w_ferr      = 1'b0;
        end
    end

    // Shift register: bits arrive LSB first, so each new bit enters at the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_rxd_s, r_shift[PAYLOAD_BITS-1:1]};
        end
    end

    // Output handshake, error pulses and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
            r_break     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_break     <= w_ferr && (r_shift == '0);
            if (w_good && (!r_valid || uart_rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
            if (w_good && r_valid && !uart_rx_ready) begin
                r_overrun <= 1'b1;
            end else if (w_consume) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign uart_rx_valid     = r_valid;
    assign uart_rx_data      = r_data;
    assign uart_rx_frame_err = r_frame_err;
    assign uart_rx_break     = r_break;
    assign uart_rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table of single frames plus hand-written sequences
// for holding, break, glitch, overrun, back-to-back, reset and enable cases.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic       uart_rx_ready = 1'b0;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;
    logic       uart_rx_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_cnt = 0;
    int brk_cnt  = 0;

    uart_rx #(
        .BIT_RATE    (100_000),
        .CLK_HZ      (1_000_000),
        .PAYLOAD_BITS(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .uart_rxd         (uart_rxd),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_ready    (uart_rx_ready),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_break    (uart_rx_break),
        .uart_rx_overrun  (uart_rx_overrun)
    );

    always #5 clk = ~clk;

    // Count single-cycle pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (uart_rx_frame_err) ferr_cnt++;
        if (uart_rx_break) brk_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; drives one 8N1 frame, each bit for CPB cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_rxd = 1'b0;
        idle(CPB);
        for (int k = 0; k < 8; k++) begin
            uart_rxd = d[k];
            idle(CPB);
        end
        uart_rxd = stop;
        idle(CPB);
        uart_rxd = 1'b1;
    endtask

    task automatic consume();
        uart_rx_ready = 1'b1;
        @(negedge clk);
        uart_rx_ready = 1'b0;
    endtask

    initial begin
        int f0;
        int b0;
        logic [7:0] last_data;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0};
        last_data = 8'h00;

        idle(4);
        check("reset valid", {31'b0, uart_rx_valid}, 0);
        check("reset data", {24'b0, uart_rx_data}, 0);
        check("reset frame_err", {31'b0, uart_rx_frame_err}, 0);
        check("reset break", {31'b0, uart_rx_break}, 0);
        check("reset overrun", {31'b0, uart_rx_overrun}, 0);
        reset = 1'b0;
        idle(5);

        // Byte held until consumed.
        send_frame(8'hA5, 1'b1);
        idle(50);
        check("hold valid", {31'b0, uart_rx_valid}, 1);
        check("hold data", {24'b0, uart_rx_data}, 32'hA5);
        consume();
        check("hold consumed valid", {31'b0, uart_rx_valid}, 0);
        check("hold consumed overrun", {31'b0, uart_rx_overrun}, 0);
        last_data = 8'hA5;
        idle(5);

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            b0 = brk_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(15);
            check("vec valid", {31'b0, uart_rx_valid}, {31'b0, vecs[i].exp_valid});
            check("vec data", {24'b0, uart_rx_data},
                  {24'b0, vecs[i].exp_valid ? vecs[i].data : last_data});
            check("vec frame_err", ferr_cnt - f0, {31'b0, vecs[i].exp_ferr});
            check("vec break", brk_cnt - b0, {31'b0, vecs[i].exp_brk});
            check("vec overrun", {31'b0, uart_rx_overrun}, 0);
            if (vecs[i].exp_valid) last_data = vecs[i].data;
            consume();
            check("vec consumed valid", {31'b0, uart_rx_valid}, 0);
            idle(5);
        end

        // Line break: low for 200 cycles.
        f0 = ferr_cnt;
        b0 = brk_cnt;
        uart_rxd = 1'b0;
        idle(200);
        check("break held frame_err", ferr_cnt - f0, 1);
        check("break held break", brk_cnt - b0, 1);
        uart_rxd = 1'b1;
        idle(30);
        check("break frame_err", ferr_cnt - f0, 1);
        check("break break", brk_cnt - b0, 1);
        check("break valid", {31'b0, uart_rx_valid}, 0);

        // 3-cycle glitch on the idle line.
        f0 = ferr_cnt;
        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(150);
        check("glitch valid", {31'b0, uart_rx_valid}, 0);
        check("glitch frame_err", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        idle(15);
        check("after glitch data", {24'b0, uart_rx_data}, 32'h3C);
        consume();
        idle(5);

        // Overrun: second byte dropped while first is held.
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(15);
        check("overrun valid", {31'b0, uart_rx_valid}, 1);
        check("overrun data", {24'b0, uart_rx_data}, 32'h12);
        check("overrun flag", {31'b0, uart_rx_overrun}, 1);
        consume();
        check("overrun consumed valid", {31'b0, uart_rx_valid}, 0);
        check("overrun consumed flag", {31'b0, uart_rx_overrun}, 0);
        idle(5);

        // Back-to-back frames, ready only on the second completion edge.
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'h3C, 1'b1);
            end
            begin
                idle(197);
                uart_rx_ready = 1'b1;
                @(negedge clk);
                uart_rx_ready = 1'b0;
            end
        join
        idle(15);
        check("b2b valid", {31'b0, uart_rx_valid}, 1);
        check("b2b data", {24'b0, uart_rx_data}, 32'h3C);
        check("b2b overrun", {31'b0, uart_rx_overrun}, 0);
        consume();
        idle(5);

        // Reset during data bit 4 of 0xFF.
        f0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(55);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        join
        idle(15);
        check("reset mid valid", {31'b0, uart_rx_valid}, 0);
        send_frame(8'h81, 1'b1);
        idle(15);
        check("after reset valid", {31'b0, uart_rx_valid}, 1);
        check("after reset data", {24'b0, uart_rx_data}, 32'h81);
        check("after reset frame_err", ferr_cnt - f0, 0);
        consume();
        idle(5);

        // Receiver disabled mid-frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(45);
                uart_rx_en = 1'b0;
                idle(10);
                uart_rx_en = 1'b1;
            end
        join
        idle(15);
        check("disable valid", {31'b0, uart_rx_valid}, 0);
        check("disable frame_err", ferr_cnt - f0, 0);
        check("disable data kept", {24'b0, uart_rx_data}, 32'h81);
        send_frame(8'h42, 1'b1);
        idle(15);
        check("after disable data", {24'b0, uart_rx_data}, 32'h42);
        check("after disable valid", {31'b0, uart_rx_valid}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
